bitwise_logic_responder: RTL and testbench
==========================================

# bitwise_logic_responder

Registered, handshaked 32-bit bitwise logic unit that answers operand-pair requests from a stimulus/initiator side. It accepts `{A, B, op}` over a valid/ready input channel and computes the result bit-serially in slices of `SLICE_W` bits. It returns the result plus a zero flag over a valid/ready output channel. It sits behind the gate-level testbenches as the clocked responder for AND/OR/XOR/NAND requests, and it counts completed transactions.

## Interface
- `DATA_W`, 32, operand/result width.
- `SLICE_W`, 8, bits processed per cycle; must divide `DATA_W` evenly; `N = DATA_W/SLICE_W`.
- `CNT_W`, 16, transaction counter width.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  responder can accept a request.
- `in_a`  in  DATA_W  operand A.
- `in_b`  in  DATA_W  operand B.
- `in_op`  in  2  00 AND, 01 OR, 10 XOR, 11 NAND.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes result.
- `out_c`  out  DATA_W  result.
- `out_zero`  out  1  `out_c == 0`.
- `txn_count`  out  CNT_W  completed output handshakes, modulo 2^CNT_W.

## Operation
- FSM states:
  - IDLE: `in_ready=1`, `out_valid=0`.
  - BUSY: slice index `k` runs 0..N-1.
  - DONE: `out_valid=1`, `in_ready=0`.
- IDLE→BUSY on `in_valid && in_ready`:
  - Latch `in_a`, `in_b`, `in_op` into internal registers.
  - Clear the result register.
  - Set `k=0`.
- In BUSY, each cycle:
  - Write the slice result to `out_c[k*SLICE_W +: SLICE_W]`, computed from the latched operands and op.
  - Increment `k`.
  - On `k==N-1`, move to DONE.
- DONE→IDLE on `out_valid && out_ready`. At that edge `txn_count` increments; it wraps from all-ones to 0.
- `out_c` and `out_zero` are held stable throughout DONE. They keep their last value in IDLE and are cleared on the next accept.
- `out_zero` is registered. It is evaluated on the full result at the BUSY→DONE edge.
- Input changes after accept have no effect; operands are latched.
- No request is accepted while in BUSY or DONE, so there is no pipelining.
- Reset (`rst_n=0` sampled at a rising edge) returns the block to IDLE from any state. The in-flight transaction is discarded and is not counted.
- Reset values: `in_ready=1`, `out_valid=0`, `out_c=0`, `out_zero=0`, `txn_count=0`.

## Timing
- Accepting edge E0. Slices are written at edges E1..EN. `out_valid` rises after EN, so latency is N edges (4 with defaults).
- Earliest next accept: the edge after the output handshake edge. Minimum period is therefore N+2 cycles per transaction with `out_ready` tied high.
- `out_ready` high during DONE: handshake at the first DONE edge.
- `out_ready` low: `out_valid` and `out_c` hold indefinitely.
- `in_valid` asserted in BUSY/DONE: ignored. The request must be held by the initiator until `in_ready`.
- Reset has priority over any simultaneous handshake.

## Structure
- Package `bitwise_logic_pkg` holds:
  - the op encodings (`OP_AND`, `OP_OR`, `OP_XOR`, `OP_NAND`);
  - the FSM state type (IDLE/BUSY/DONE).
- Sub-module `logic_slice` is combinational. It takes a SLICE_W-bit a/b and the op, and produces the slice result. It is instantiated once and muxed by `k`.

## Test plan
- Reset, idle: hold `rst_n=0` for 2 cycles. Required: `in_ready=1`, `out_valid=0`, `out_c=0`, `txn_count=0`.
- AND sweep with `out_ready=1`:
  - `(1234,0)` → 0, `out_zero=1`.
  - `(1234,1234)` → 1234.
  - `(0,9999)` → 0.
  - `(99999,9999)` → 1551 (`0x60F`).
  - Each result appears exactly 4 edges after accept; `txn_count=4` at the end.
- Other ops on `(99999,9999)`:
  - OR → `0x1A79F`.
  - XOR → `0x1A190`.
  - NAND → `~0x60F` (`0xFFFFF9F0`), `out_zero=0`.
- Backpressure: hold `out_ready=0` for 10 cycles in DONE. Required: `out_c` is stable and `in_ready=0`; a new `in_valid` is not accepted; the count increments once on release.
- Mid-operation reset: assert `rst_n=0` at k=2. Required: IDLE on the next edge, outputs at reset values, `txn_count` unchanged (0 after reset).
- Counter wrap with `CNT_W=4`: 17 transactions. Required: `txn_count=1`.

Source files
------------

// File: rtl/bitwise_logic_pkg.sv
// rtl/bitwise_logic_pkg.sv - op encodings and FSM state type for the bitwise logic responder
package bitwise_logic_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/logic_slice.sv
// rtl/logic_slice.sv - combinational SLICE_W-bit AND/OR/XOR/NAND slice
//
// Ports:
//   a, b  slice operands
//   op    operation select
//   c     slice result
module logic_slice
    import bitwise_logic_pkg::*;
#(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  op_e                op,
    output logic [SLICE_W-1:0] c
);

    always_comb begin
        c = '0;
        case (op)
            OP_AND:  c = a & b;
            OP_OR:   c = a | b;
            OP_XOR:  c = a ^ b;
            OP_NAND: c = ~(a & b);
            default: c = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_responder.sv
// rtl/bitwise_logic_responder.sv - handshaked bit-serial 32-bit logic unit with transaction counter
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready           request channel carrying in_a, in_b, in_op
//   out_valid/out_ready         response channel carrying out_c, out_zero
//   txn_count                   completed output handshakes, wrapping
module bitwise_logic_responder
    import bitwise_logic_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_c,
    output logic              out_zero,
    output logic [CNT_W-1:0]  txn_count
);

    localparam int N   = DATA_W / SLICE_W;
    localparam int K_W = (N > 1) ? $clog2(N) : 1;

    state_e              state;
    state_e              state_nxt;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    op_e                 op_q;
    logic [K_W-1:0]      k;
    logic                last_slice;
    logic [SLICE_W-1:0]  slice_a;
    logic [SLICE_W-1:0]  slice_b;
    logic [SLICE_W-1:0]  slice_c;
    logic [DATA_W-1:0]   c_nxt;

    assign last_slice = (k == K_W'(N - 1));

    // One slice unit shared across all k; operands selected by the slice index.
    assign slice_a = a_q[int'(k) * SLICE_W +: SLICE_W];
    assign slice_b = b_q[int'(k) * SLICE_W +: SLICE_W];

    logic_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .op (op_q),
        .c  (slice_c)
    );

    // Result with the current slice merged in; at the last slice this is the
    // complete result, so the zero flag can be taken from it on the same edge.
    always_comb begin
        c_nxt = out_c;
        c_nxt[int'(k) * SLICE_W +: SLICE_W] = slice_c;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (last_slice) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_AND;
            k         <= '0;
            out_c     <= '0;
            out_zero  <= 1'b0;
            txn_count <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        op_q     <= op_e'(in_op);
                        k        <= '0;
                        out_c    <= '0;
                        out_zero <= 1'b0;
                    end
                end
                BUSY: begin
                    out_c <= c_nxt;
                    k     <= k + K_W'(1);
                    if (last_slice) begin
                        out_zero <= (c_nxt == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        txn_count <= txn_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bitwise_logic_responder.sv
// tb/tb_bitwise_logic_responder.sv - self-checking bench for bitwise_logic_responder
module tb_bitwise_logic_responder;
    import bitwise_logic_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] c;
        logic        z;
    } vec_t;

    typedef struct {
        logic [31:0] c;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_op;
    logic        out_ready;

    logic        in_ready, out_valid, out_zero;
    logic [31:0] out_c;
    logic [15:0] txn_count;

    logic        w_in_ready, w_out_valid, w_out_zero;
    logic [31:0] w_out_c;
    logic [3:0]  w_txn_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;
    exp_t sb[$];
    vec_t vecs[11];

    always #5 clk = ~clk;

    bitwise_logic_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_zero  (out_zero),
        .txn_count (txn_count)
    );

    bitwise_logic_responder #(.CNT_W(4)) dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .out_c     (w_out_c),
        .out_zero  (w_out_zero),
        .txn_count (w_txn_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // Scoreboard consumer: the negedge before each output handshake edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb out_c", out_c, e.c);
                check("sb out_zero", 32'(out_zero), 32'(e.z));
            end
        end
    end

    // Entered #1 after a rising edge; leaves #1 after the output handshake edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [31:0] ec, input logic ez, input int hold);
        int   n;
        exp_t e;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = (hold == 0);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept wait", 32'(n < 50), 32'd1);
        e.c = ec;
        e.z = ez;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_op    = 2'($urandom_range(0, 3));
        check("busy in_ready", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'd4);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_a     = ~a;
            in_b     = ~b;
            @(posedge clk); #1;
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold out_c", out_c, ec);
            check("hold in_ready", 32'(in_ready), 32'd0);
        end
        if (hold > 0) begin
            check("hold count", 32'(txn_count), 32'(exp_cnt));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_cnt++;
        check("post out_valid", 32'(out_valid), 32'd0);
        check("post in_ready", 32'(in_ready), 32'd1);
        check("post out_c held", out_c, ec);
        check("txn_count", 32'(txn_count), 32'(exp_cnt % 65536));
        check("w txn_count", 32'(w_txn_count), 32'(exp_cnt % 16));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'd1234,       32'd0,          2'b00, 32'd0,          1'b1};
        vecs[1]  = '{32'd1234,       32'd1234,       2'b00, 32'd1234,       1'b0};
        vecs[2]  = '{32'd0,          32'd9999,       2'b00, 32'd0,          1'b1};
        vecs[3]  = '{32'd99999,      32'd9999,       2'b00, 32'h0000_060F,  1'b0};
        vecs[4]  = '{32'd99999,      32'd9999,       2'b01, 32'h0001_A79F,  1'b0};
        vecs[5]  = '{32'd99999,      32'd9999,       2'b10, 32'h0001_A190,  1'b0};
        vecs[6]  = '{32'd99999,      32'd9999,       2'b11, 32'hFFFF_F9F0,  1'b0};
        vecs[7]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  2'b10, 32'h0000_0000,  1'b1};
        vecs[8]  = '{32'h8000_0000,  32'h0000_0000,  2'b01, 32'h8000_0000,  1'b0};
        vecs[9]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  2'b11, 32'h0000_0000,  1'b1};
        vecs[10] = '{32'hA5A5_A5A5,  32'h0F0F_0F0F,  2'b00, 32'h0505_0505,  1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = 2'b00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_c", out_c, 32'd0);
        check("rst out_zero", 32'(out_zero), 32'd0);
        check("rst txn_count", 32'(txn_count), 32'd0);
        check("rst w txn_count", 32'(w_txn_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].c, vecs[i].z, 0);
            if (i == 3) begin
                check("and sweep count", 32'(txn_count), 32'd4);
            end
        end

        send(32'd99999, 32'd9999, 2'b10, 32'h0001_A190, 1'b0, 10);

        // Reset while the third slice is about to be written.
        in_valid  = 1'b1;
        in_a      = 32'hFFFF_FFFF;
        in_b      = 32'h0;
        in_op     = 2'b01;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midop partial out_c", out_c, 32'h0000_FFFF);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midop in_ready", 32'(in_ready), 32'd1);
        check("midop out_valid", 32'(out_valid), 32'd0);
        check("midop out_c", out_c, 32'd0);
        check("midop out_zero", 32'(out_zero), 32'd0);
        check("midop txn_count", 32'(txn_count), 32'd0);
        rst_n   = 1'b1;
        exp_cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            check("midop stays idle", 32'(out_valid), 32'd0);
        end

        for (int i = 0; i < 17; i++) begin
            logic [31:0] a, b;
            logic [1:0]  op;
            logic [31:0] c;
            a  = $urandom;
            b  = $urandom;
            op = 2'($urandom_range(0, 3));
            c  = model(a, b, op);
            send(a, b, op, c, (c == 32'd0), 0);
        end
        check("wrap w txn_count", 32'(w_txn_count), 32'd1);
        check("wrap txn_count", 32'(txn_count), 32'd17);
        check("sb drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
